mem_write_arbiter: RTL and testbench
====================================

MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

Interface
REQ-001 Parameter: DEPTH, default 8, byte-address width of the shared 32-bit memory; the memory holds 2**(DEPTH-2) words.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid_i / req1_valid_i  input  1 each  requester N has a write pending (req0 = core store unit, req1 = loader/debug).
REQ-005 req0_addr_i / req1_addr_i  input  DEPTH each  byte address of the write.
REQ-006 req0_data_i / req1_data_i  input  32 each  write data.
REQ-007 req0_lock_i / req1_lock_i  input  1 each  requester N asks to keep ownership after its current beat.
REQ-008 req0_ready_o / req1_ready_o  output  1 each  the write of requester N is accepted this cycle.
REQ-009 write_o  output  1  write enable to the memory write port.
REQ-010 wr_addr_o  output  DEPTH  write address to the memory.
REQ-011 wr_data_o  output  32  write data to the memory.
REQ-012 misalign_o  output  1  sticky flag: an accepted address had bits [1:0] != 0.
REQ-013 wr_count_o  output  16  count of writes issued to the memory.

Function
REQ-014 Transfer rule: a beat transfers on requester N when reqN_valid_i && reqN_ready_o at posedge clk.
REQ-015 Ready rule: reqN_ready_o SHALL be combinational from state and the valid inputs; at most one ready SHALL be high in any cycle.
REQ-016 Ready independence: a ready SHALL never depend on that requester's own data or address inputs.
REQ-017 State machine: three states, IDLE, LOCK0 and LOCK1.
REQ-018 IDLE, one requester valid: grant that requester.
REQ-019 IDLE, both requesters valid: grant the requester that was not granted last (round-robin); the pointer resets to "last = 1", so req0 wins first.
REQ-020 LOCKn: grant only requester n; the other requester's ready SHALL stay 0 even if it is valid.
REQ-021 Enter LOCKn on a transfer by requester n with reqn_lock_i = 1.
REQ-022 Leave LOCKn for IDLE on a transfer by requester n with reqn_lock_i = 0.
REQ-023 LOCKn with reqn_valid_i = 0: remain in LOCKn and grant nobody.
REQ-024 Output register: an accepted beat SHALL appear on write_o/wr_addr_o/wr_data_o exactly 1 cycle after the transfer edge; write_o SHALL be high for exactly one cycle per beat.
REQ-025 No transfer in a cycle: write_o SHALL be 0 in the following cycle; wr_addr_o and wr_data_o hold their last values.
REQ-026 Throughput: one beat per cycle sustained; back-to-back beats from alternating or locked requesters SHALL produce no bubbles.
REQ-027 Address passthrough: the address SHALL pass unmodified, including bits [1:0], which the memory ignores.
REQ-028 Misalign flag: if addr[1:0] != 0 on a transfer, misalign_o SHALL set in the next cycle and stay set until reset; the write SHALL still be issued.
REQ-029 Write counter: wr_count_o SHALL increment by 1 in the cycle write_o is high and wrap from 16'hFFFF to 0.
REQ-030 Pointer update: the round-robin pointer SHALL update only on a transfer.

Reset
REQ-031 On rst = 1 at posedge clk the block SHALL load: state IDLE, pointer last = 1, write_o = 0, wr_addr_o = 0, wr_data_o = 0, misalign_o = 0, wr_count_o = 0.
REQ-032 While rst is high, both readies SHALL be 0.
REQ-033 Reset asserted mid-lock: return to IDLE; a beat accepted in the cycle before reset SHALL NOT be issued (write_o = 0 after reset).

Verification
REQ-034 Single writer: req0 valid, addr 8'h10, data 32'hDEADBEEF for one cycle -> req0_ready_o = 1 that cycle; next cycle write_o = 1, wr_addr_o = 8'h10, wr_data_o = 32'hDEADBEEF; wr_count_o = 1 one cycle later.
REQ-035 Contention: both requesters valid for 4 cycles after reset -> grants 0,1,0,1; four consecutive write_o pulses with the matching data; no cycle with both readies high.
REQ-036 Lock: req1 issues 3 beats with lock = 1,1,0 while req0 stays valid -> req0_ready_o = 0 for those 3 cycles; req0 is granted in the 4th cycle.
REQ-037 Misalign: req0 writes addr 8'h13 -> write issued with wr_addr_o = 8'h13; misalign_o = 1 and stays 1 through later aligned writes until rst.
REQ-038 Reset mid-operation: rst asserted in LOCK0 the cycle after a transfer -> write_o = 0, wr_count_o = 0, state IDLE, and req1 is granted first if it alone is valid after reset.
REQ-039 Counter wrap: preload via 65535 writes, then issue one more write -> wr_count_o = 16'h0000.

Source files
------------

// File: rtl/mem_write_arbiter.sv
// Two-requester write arbiter for a shared 32-bit memory port.
// Round-robin arbitration with lock, plus a registered write stage, misalign flag and write counter.
module mem_write_arbiter #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  input  logic [DEPTH-1:0] req0_addr_i,
  input  logic [31:0]      req0_data_i,
  input  logic             req0_lock_i,
  input  logic             req1_valid_i,
  input  logic [DEPTH-1:0] req1_addr_i,
  input  logic [31:0]      req1_data_i,
  input  logic             req1_lock_i,
  output logic             req0_ready_o,
  output logic             req1_ready_o,
  output logic             write_o,
  output logic [DEPTH-1:0] wr_addr_o,
  output logic [31:0]      wr_data_o,
  output logic             misalign_o,
  output logic [15:0]      wr_count_o
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t           state;
  logic             last_grant;
  logic             xfer0;
  logic             xfer1;
  logic [DEPTH-1:0] sel_addr;
  logic [31:0]      sel_data;
  logic             sel_lock;

  // Readies depend only on state and valids; last_grant = 1 means req1 won last, so req0 wins a tie.
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          req0_ready_o = req0_valid_i && (!req1_valid_i || last_grant);
          req1_ready_o = req1_valid_i && (!req0_valid_i || !last_grant);
        end
        LOCK0:   req0_ready_o = req0_valid_i;
        LOCK1:   req1_ready_o = req1_valid_i;
        default: begin
          req0_ready_o = 1'b0;
          req1_ready_o = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    xfer0    = req0_valid_i && req0_ready_o;
    xfer1    = req1_valid_i && req1_ready_o;
    sel_addr = xfer1 ? req1_addr_i : req0_addr_i;
    sel_data = xfer1 ? req1_data_i : req0_data_i;
    sel_lock = xfer1 ? req1_lock_i : req0_lock_i;
  end

  // The counter lags write_o by one cycle so it counts beats actually presented to the memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      write_o    <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      misalign_o <= 1'b0;
      wr_count_o <= '0;
    end else begin
      write_o    <= xfer0 || xfer1;
      wr_count_o <= wr_count_o + {15'd0, write_o};
      if (xfer0 || xfer1) begin
        wr_addr_o  <= sel_addr;
        wr_data_o  <= sel_data;
        last_grant <= xfer1;
        if (sel_addr[1:0] != 2'b00)
          misalign_o <= 1'b1;
        if (sel_lock)
          state <= xfer1 ? LOCK1 : LOCK0;
        else
          state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Self-checking bench for mem_write_arbiter: directed scenarios with literal expectations,
// then random traffic, all compared each cycle against a transaction-level model.
module tb_mem_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid_i, req0_lock_i, req1_valid_i, req1_lock_i;
  logic [7:0]  req0_addr_i, req1_addr_i;
  logic [31:0] req0_data_i, req1_data_i;
  logic        req0_ready_o, req1_ready_o, write_o, misalign_o;
  logic [7:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic [15:0] wr_count_o;

  int tests = 0;
  int fails = 0;

  mem_write_arbiter #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i),
    .req0_data_i(req0_data_i), .req0_lock_i(req0_lock_i),
    .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i),
    .req1_data_i(req1_data_i), .req1_lock_i(req1_lock_i),
    .req0_ready_o(req0_ready_o), .req1_ready_o(req1_ready_o),
    .write_o(write_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .misalign_o(misalign_o), .wr_count_o(wr_count_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r,
                               input logic v0, input logic l0, input logic [7:0] a0, input logic [31:0] d0,
                               input logic v1, input logic l1, input logic [7:0] a1, input logic [31:0] d1);
    @(negedge clk);
    rst = r;
    req0_valid_i = v0; req0_lock_i = l0; req0_addr_i = a0; req0_data_i = d0;
    req1_valid_i = v1; req1_lock_i = l1; req1_addr_i = a1; req1_data_i = d1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  // Reference model: who owns the port (-1 nobody), who won last, and the expected registered outputs.
  int          owner;
  int          last;
  bit          model_valid = 1'b0;
  logic        m_write;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic        m_mis;
  logic [15:0] m_count;
  int          g;

  function automatic int modelGrant();
    if (rst) return -1;
    if (owner == 0) return req0_valid_i ? 0 : -1;
    if (owner == 1) return req1_valid_i ? 1 : -1;
    if (req0_valid_i && req1_valid_i) return 1 - last;
    if (req0_valid_i) return 0;
    if (req1_valid_i) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    #2;
    g = modelGrant();
    if (model_valid || rst === 1'b1) begin
      checkOutput("req0_ready", 32'(req0_ready_o), 32'(g == 0));
      checkOutput("req1_ready", 32'(req1_ready_o), 32'(g == 1));
      checkOutput("ready_onehot", 32'(req0_ready_o & req1_ready_o), 32'd0);
    end
    if (model_valid) begin
      checkOutput("write_o", 32'(write_o), 32'(m_write));
      checkOutput("wr_addr", 32'(wr_addr_o), 32'(m_addr));
      checkOutput("wr_data", wr_data_o, m_data);
      checkOutput("misalign", 32'(misalign_o), 32'(m_mis));
      checkOutput("wr_count", 32'(wr_count_o), 32'(m_count));
    end
    if (rst === 1'b1) begin
      owner = -1; last = 1; m_write = 1'b0; m_addr = 8'h0; m_data = 32'h0;
      m_mis = 1'b0; m_count = 16'h0; model_valid = 1'b1;
    end else if (model_valid) begin
      m_count = m_count + 16'(m_write);
      m_write = (g >= 0);
      if (g >= 0) begin
        m_addr = (g == 0) ? req0_addr_i : req1_addr_i;
        m_data = (g == 0) ? req0_data_i : req1_data_i;
        if (m_addr % 4 != 0) m_mis = 1'b1;
        last  = g;
        owner = ((g == 0) ? req0_lock_i : req1_lock_i) ? g : -1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req0_valid_i = 1'b0; req0_lock_i = 1'b0; req0_addr_i = 8'h0; req0_data_i = 32'h0;
    req1_valid_i = 1'b0; req1_lock_i = 1'b0; req1_addr_i = 8'h0; req1_data_i = 32'h0;
    resetCycle();
    idleCycles(1);
    #3;
    checkOutput("lit_reset_write", 32'(write_o), 32'd0);
    checkOutput("lit_reset_count", 32'(wr_count_o), 32'd0);

    // Single writer
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 8'h0, 32'h0);
    #3 checkOutput("lit_single_ready", 32'(req0_ready_o), 32'd1);
    idleCycles(1);
    #3;
    checkOutput("lit_single_write", 32'(write_o), 32'd1);
    checkOutput("lit_single_addr", 32'(wr_addr_o), 32'h10);
    checkOutput("lit_single_data", wr_data_o, 32'hDEADBEEF);
    idleCycles(1);
    #3 checkOutput("lit_single_count", 32'(wr_count_o), 32'd1);

    // Contention right after reset: 0,1,0,1
    resetCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h20, 32'hA0A00000 + k, 1'b1, 1'b0, 8'h24, 32'hB0B00000 + k);
      #3 checkOutput("lit_rr_req0", 32'(req0_ready_o), 32'(k % 2 == 0));
    end
    idleCycles(1);
    #3 checkOutput("lit_rr_last_data", wr_data_o, 32'hB0B00003);

    // Locked burst from req1 while req0 keeps asking
    resetCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 32'h11111111, 1'b0, 1'b0, 8'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h04, 32'h22222222, 1'b1, (k < 2), 8'h08, 32'h33330000 + k);
      #3;
      checkOutput("lit_lock_req0_blocked", 32'(req0_ready_o), 32'd0);
      checkOutput("lit_lock_req1_granted", 32'(req1_ready_o), 32'd1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h04, 32'h22222222, 1'b1, 1'b0, 8'h08, 32'h44444444);
    #3 checkOutput("lit_lock_req0_after", 32'(req0_ready_o), 32'd1);

    // Misalign is sticky through aligned writes
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h13, 32'h13131313, 1'b0, 1'b0, 8'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h20, 32'h20202020);
    #3;
    checkOutput("lit_mis_addr", 32'(wr_addr_o), 32'h13);
    checkOutput("lit_mis_flag", 32'(misalign_o), 32'd1);
    idleCycles(2);
    #3 checkOutput("lit_mis_sticky", 32'(misalign_o), 32'd1);

    // Reset while in LOCK0, the cycle after a transfer
    resetCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h30, 32'h30303030, 1'b0, 1'b0, 8'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h34, 32'h34343434, 1'b1, 1'b0, 8'h38, 32'h38383838);
    #3 checkOutput("lit_rst_ready0", 32'(req0_ready_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h3C, 32'h3C3C3C3C);
    #3;
    checkOutput("lit_rst_write", 32'(write_o), 32'd0);
    checkOutput("lit_rst_count", 32'(wr_count_o), 32'd0);
    checkOutput("lit_rst_req1_first", 32'(req1_ready_o), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(63) == 0),
                    ($urandom_range(3) != 0), ($urandom_range(2) == 0), 8'($urandom), $urandom,
                    ($urandom_range(3) != 0), ($urandom_range(2) == 0), 8'($urandom), $urandom);
    end

    // Counter wrap
    resetCycle();
    for (int i = 0; i < 65535; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(i) & 8'hFC, 32'(i), 1'b0, 1'b0, 8'h0, 32'h0);
    idleCycles(2);
    #3 checkOutput("lit_count_ffff", 32'(wr_count_o), 32'h0000FFFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 8'h40, 32'hCAFEF00D);
    idleCycles(2);
    #3 checkOutput("lit_count_wrap", 32'(wr_count_o), 32'h00000000);

    idleCycles(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
